// File: rtl/edulent_mem_arbiter.sv
// edulent_mem_arbiter: shares the single-port edulent memory between the CPU
// data path (port 0) and the debug/program loader (port 1). Each access is a
// single-beat transaction; the winner gets a one-cycle ack and, for reads,
// the captured memory data. Arbitration is round-robin or fixed priority.
module edulent_mem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_req0,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [DATA_W-1:0] i_wdata0,
    output logic              o_ack0,
    output logic [DATA_W-1:0] o_rdata0,

    input  logic              i_req1,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_ack1,
    output logic [DATA_W-1:0] o_rdata1,

    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data_write,
    output logic              o_mem_write_enable,
    input  logic [DATA_W-1:0] i_mem_data_read,

    output logic              o_busy,
    output logic              o_owner
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    // Read wait count in the 3-bit counter domain.
    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    logic [1:0]        state;
    logic [2:0]        lat_cnt;
    logic              last_port;

    logic              elig0;
    logic              elig1;
    logic              grant_vld;
    logic              grant_port;
    logic              grant_we;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wdata;

    // Winner selection when both ports are eligible; with a single eligible
    // port that port is returned.
    function automatic logic pick_port(input logic e0, input logic e1,
                                       input logic last);
        if (e0 && e1) begin
            return (FIXED_PRIO != 0) ? 1'b0 : ~last;
        end
        return e1;
    endfunction

    // Eligibility and candidate transaction for the next IDLE edge; a port
    // whose ack is high this cycle is masked so a still-held request is not
    // granted twice.
    always_comb begin
        elig0       = i_req0 & ~o_ack0;
        elig1       = i_req1 & ~o_ack1;
        grant_vld   = elig0 | elig1;
        grant_port  = pick_port(elig0, elig1, last_port);
        grant_we    = grant_port ? i_we1    : i_we0;
        grant_addr  = grant_port ? i_addr1  : i_addr0;
        grant_wdata = grant_port ? i_wdata1 : i_wdata0;
    end

    // Transaction FSM with registered memory-side and requester-side outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state              <= ST_IDLE;
            lat_cnt            <= '0;
            last_port          <= 1'b1;
            o_ack0             <= 1'b0;
            o_ack1             <= 1'b0;
            o_rdata0           <= '0;
            o_rdata1           <= '0;
            o_mem_addr         <= '0;
            o_mem_data_write   <= '0;
            o_mem_write_enable <= 1'b0;
            o_busy             <= 1'b0;
            o_owner            <= 1'b0;
        end else begin
            o_ack0 <= 1'b0;
            o_ack1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    o_mem_write_enable <= 1'b0;
                    if (grant_vld) begin
                        o_mem_addr       <= grant_addr;
                        o_mem_data_write <= grant_wdata;
                        o_owner          <= grant_port;
                        o_busy           <= 1'b1;
                        last_port        <= grant_port;
                        if (grant_we) begin
                            state              <= ST_WRITE;
                            o_mem_write_enable <= 1'b1;
                        end else begin
                            state   <= ST_READ;
                            lat_cnt <= '0;
                        end
                    end
                end
                ST_WRITE: begin
                    // Memory samples the strobe at this edge.
                    o_mem_write_enable <= 1'b0;
                    o_busy             <= 1'b0;
                    state              <= ST_IDLE;
                    if (o_owner) begin
                        o_ack1 <= 1'b1;
                    end else begin
                        o_ack0 <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (lat_cnt == LAT) begin
                        o_busy <= 1'b0;
                        state  <= ST_IDLE;
                        if (o_owner) begin
                            o_ack1   <= 1'b1;
                            o_rdata1 <= i_mem_data_read;
                        end else begin
                            o_ack0   <= 1'b1;
                            o_rdata0 <= i_mem_data_read;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                default: begin
                    state              <= ST_IDLE;
                    o_busy             <= 1'b0;
                    o_mem_write_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule
